// File: rtl/fwft_fifo_downsizer_if.sv
// Handshake bundle between an FWFT FIFO read port, the downsizer and a narrow valid/ready sink.
interface fwft_fifo_downsizer_if #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
);
  logic                 fifo_empty;
  logic [IN_WIDTH-1:0]  fifo_dout;
  logic                 fifo_read;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_ready;
  logic                 busy;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_read, out_valid, out_data, out_last, busy
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_read, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/fwft_fifo_downsizer.sv
// Pops wide words from an FWFT FIFO and streams them out as RATIO narrow slices,
// reloading on the last accepted slice so consecutive words leave without a bubble.
module fwft_fifo_downsizer #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fwft_fifo_downsizer_if.master       bus
);

  localparam int unsigned IdxW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(RATIO - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                r_state;
  logic [IN_WIDTH-1:0]   r_word;
  logic [IdxW-1:0]       r_idx;

  logic                  w_send;
  logic                  w_last;
  logic                  w_accept;
  logic [IdxW-1:0]       w_sel;
  logic [OUT_WIDTH-1:0]  w_slice;

  assign w_send   = (r_state == StSend);
  assign w_last   = w_send && (r_idx == LastIdx);
  assign w_accept = w_send && bus.out_ready;
  assign w_sel    = (MSB_FIRST != 0) ? (LastIdx - r_idx) : r_idx;

  // Pop is gated by rst_n so the FIFO is never drained while the block is held in reset.
  assign bus.fifo_read = rst_n & ~bus.fifo_empty & (~w_send | (w_last & bus.out_ready));

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (w_sel == IdxW'(i)) begin
        w_slice = r_word[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  assign bus.out_valid = w_send;
  assign bus.out_data  = w_slice;
  assign bus.out_last  = w_last;
  assign bus.busy      = w_send;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      if (bus.fifo_read) begin
        r_word  <= bus.fifo_dout;
        r_idx   <= '0;
        r_state <= StSend;
      end else if (w_accept) begin
        if (w_last) begin
          r_state <= StIdle;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fwft_fifo_downsizer.sv
// Randomised bench: a queue-based FIFO and a word/slice-count reference model drive
// two downsizers (LSB-first and MSB-first) with identical stimulus.
module tb_fwft_fifo_downsizer;
  localparam int unsigned InW   = 32;
  localparam int unsigned Ratio = 4;
  localparam int unsigned OutW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwft_fifo_downsizer_if #(.IN_WIDTH(InW), .OUT_WIDTH(OutW)) bus0 ();
  fwft_fifo_downsizer_if #(.IN_WIDTH(InW), .OUT_WIDTH(OutW)) bus1 ();

  fwft_fifo_downsizer #(.IN_WIDTH(InW), .RATIO(Ratio), .OUT_WIDTH(OutW), .MSB_FIRST(0)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fwft_fifo_downsizer #(.IN_WIDTH(InW), .RATIO(Ratio), .OUT_WIDTH(OutW), .MSB_FIRST(1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [InW-1:0] fq[$];
  bit             m_held = 1'b0;
  logic [InW-1:0] m_word = '0;
  int             m_sent = 0;
  int             n_reads = 0;
  int             n_acc = 0;
  int             ready_mode = 0;
  int             cyc = 0;
  logic           rdy = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [OutW-1:0] slice_of(input logic [InW-1:0] w, input int i,
                                               input bit msb);
    int k;
    k = msb ? (Ratio - 1 - i) : i;
    return OutW'(w >> (k * OutW));
  endfunction

  task automatic drive();
    logic [InW-1:0] d;
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    d = (fq.size() > 0) ? fq[0] : InW'($urandom);
    bus0.fifo_empty = (fq.size() == 0);
    bus1.fifo_empty = (fq.size() == 0);
    bus0.fifo_dout  = d;
    bus1.fifo_dout  = d;
    bus0.out_ready  = rdy;
    bus1.out_ready  = rdy;
  endtask

  // One clock: compare at negedge, then advance the model after the posedge.
  task automatic tick();
    bit             exp_read;
    bit             acc;
    logic [InW-1:0] popw;
    @(negedge clk);
    exp_read = rst_n && (fq.size() > 0) && (!m_held || ((m_sent == Ratio - 1) && rdy));
    check("valid_lsb", 32'(bus0.out_valid), 32'(m_held));
    check("valid_msb", 32'(bus1.out_valid), 32'(m_held));
    check("busy",      32'(bus0.busy),      32'(m_held));
    check("last",      32'(bus0.out_last),  32'(m_held && (m_sent == Ratio - 1)));
    check("read_lsb",  32'(bus0.fifo_read), 32'(exp_read));
    check("read_msb",  32'(bus1.fifo_read), 32'(exp_read));
    if (m_held) begin
      check("data_lsb", 32'(bus0.out_data), 32'(slice_of(m_word, m_sent, 1'b0)));
      check("data_msb", 32'(bus1.out_data), 32'(slice_of(m_word, m_sent, 1'b1)));
    end
    if (!rst_n) check("data_rst", 32'(bus0.out_data), 32'h0);
    acc  = m_held && rdy;
    popw = (fq.size() > 0) ? fq[0] : '0;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (acc) begin
        m_sent++;
        n_acc++;
        if (m_sent == Ratio) m_held = 1'b0;
      end
      if (exp_read) begin
        void'(fq.pop_front());
        n_reads++;
        m_held = 1'b1;
        m_word = popw;
        m_sent = 0;
      end
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_held || fq.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(m_held || fq.size() > 0), 32'h0);
  endtask

  initial begin
    int reads0;
    int acc0;
    int pushed;
    int budget;

    // Reset held with a non-empty FIFO: nothing may be popped.
    fq.push_back(32'hCAFE_F00D);
    drive();
    repeat (3) tick();
    fq.delete();
    drive();
    #2 rst_n = 1'b1;
    tick();

    // Single word, sink always ready.
    fq.push_back(32'hDDCC_BBAA);
    drive();
    drain(20);
    check("idle_valid", 32'(bus0.out_valid), 32'h0);
    check("idle_busy",  32'(bus0.busy),      32'h0);

    // Two preloaded words stream back-to-back; exactly two pops.
    reads0 = n_reads;
    acc0   = n_acc;
    fq.push_back(32'h0302_0100);
    fq.push_back(32'h0706_0504);
    drive();
    repeat (9) tick();
    check("b2b_reads", 32'(n_reads - reads0), 32'd2);
    check("b2b_slices", 32'(n_acc - acc0), 32'd8);
    drain(10);

    // MSB-first lane on a directed word (LSB lane checked alongside).
    fq.push_back(32'h1122_3344);
    drive();
    drain(20);

    // 100 random words under 1,0,0,1 backpressure then random backpressure.
    for (int mode = 1; mode <= 2; mode++) begin
      ready_mode = mode;
      acc0   = n_acc;
      pushed = 0;
      budget = 0;
      while ((pushed < 100 || m_held || fq.size() > 0) && budget < 4000) begin
        if (pushed < 100 && $urandom_range(0, 2) != 0) begin
          fq.push_back(InW'($urandom));
          pushed++;
          drive();
        end
        tick();
        budget++;
      end
      check("rand_slices", 32'(n_acc - acc0), 32'(100 * Ratio));
    end
    ready_mode = 0;
    drive();

    // Reset after the second slice: the held word must be dropped, not replayed.
    fq.push_back(32'hDDCC_BBAA);
    drive();
    repeat (3) tick();
    check("pre_rst_sent", 32'(m_sent), 32'd2);
    rst_n  = 1'b0;
    m_held = 1'b0;
    m_sent = 0;
    fq.push_back(32'h4433_2211);
    drive();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_first", 32'(bus0.out_data), 32'h11);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
